cordic_sequencer: RTL and testbench

CORDIC_SEQUENCER -- requirements
Module: cordic_sequencer

---
 rtl/cordic_sequencer_if.sv | 26 ++
 rtl/cordic_sequencer.sv | 148 ++++++++++++++
 tb/tb_cordic_sequencer.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/cordic_sequencer_if.sv
// Input-vector and result handshakes of the CORDIC sequencer.
// The sequencer connects through the slave modport; the upstream/downstream side uses master.
interface cordic_sequencer_if #(
  parameter int unsigned COORD_DEPTH = 8,
  parameter int unsigned ANGLE_DEPTH = 10
);
  logic                          in_valid;
  logic                          in_ready;
  logic signed [COORD_DEPTH-1:0] x_in;
  logic signed [COORD_DEPTH-1:0] y_in;
  logic                          out_valid;
  logic                          out_ready;
  logic        [ANGLE_DEPTH-1:0] angle_out;
  logic                          out_zero;
  logic                          out_err;

  modport master (
    output in_valid, x_in, y_in, out_ready,
    input  in_ready, out_valid, angle_out, out_zero, out_err
  );

  modport slave (
    input  in_valid, x_in, y_in, out_ready,
    output in_ready, out_valid, angle_out, out_zero, out_err
  );
endinterface

// File: rtl/cordic_sequencer.sv
// Sequencer for an iterative CORDIC vectoring stage: pre-rotates into the right half-plane,
// drives the per-iteration index and arctan entry, then normalises the returned angle.
module cordic_sequencer #(
  parameter int unsigned ITERATIONS  = 20,
  parameter int unsigned COORD_DEPTH = 8,
  parameter int unsigned ANGLE_DEPTH = 10
) (
  input  logic                          clk,
  input  logic                          rst,
  cordic_sequencer_if.slave             bus,
  output logic                          cordic_start,
  output logic [4:0]                    cordic_k,
  output logic [ANGLE_DEPTH-1:0]        cordic_LUT_k,
  output logic signed [COORD_DEPTH-1:0] cordic_x,
  output logic signed [COORD_DEPTH-1:0] cordic_y,
  output logic [ANGLE_DEPTH-1:0]        cordic_angle_begin,
  input  logic                          cordic_rdy,
  input  logic [ANGLE_DEPTH-1:0]        cordic_angle
);

  localparam int unsigned TmrW = $clog2(ITERATIONS + 5);

  typedef enum logic [2:0] {StIdle, StIssue, StRun, StWait, StOut} state_e;

  state_e                        state_q;
  logic                          start_q;
  logic [4:0]                    k_q;
  logic [TmrW-1:0]               tmr_q;
  logic signed [COORD_DEPTH-1:0] x_q, y_q;
  logic [ANGLE_DEPTH-1:0]        ang_begin_q;
  logic [ANGLE_DEPTH-1:0]        angle_q;
  logic                          valid_q, zero_q, err_q;

  logic signed [COORD_DEPTH-1:0] x_half, y_half, x_rot, y_rot;
  logic                          x_neg;
  logic                          coords_zero;
  logic [ANGLE_DEPTH-1:0]        angle_norm;

  // Halving first keeps the negation of the most negative input in range.
  always_comb begin
    x_half = $signed(bus.x_in) >>> 1;
    y_half = $signed(bus.y_in) >>> 1;
    x_neg  = x_half[COORD_DEPTH-1];
    x_rot  = x_neg ? -x_half : x_half;
    y_rot  = x_neg ? -y_half : y_half;
  end

  assign coords_zero = (x_q == '0) && (y_q == '0);
  assign angle_norm  = cordic_angle[ANGLE_DEPTH-1] ? cordic_angle + ANGLE_DEPTH'(360)
                                                   : cordic_angle;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      start_q     <= 1'b0;
      k_q         <= '0;
      tmr_q       <= '0;
      x_q         <= '0;
      y_q         <= '0;
      ang_begin_q <= '0;
      angle_q     <= '0;
      valid_q     <= 1'b0;
      zero_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (bus.in_valid) begin
            x_q         <= x_rot;
            y_q         <= y_rot;
            ang_begin_q <= x_neg ? ANGLE_DEPTH'(180) : '0;
            angle_q     <= '0;
            zero_q      <= 1'b0;
            err_q       <= 1'b0;
            start_q     <= 1'b1;
            k_q         <= '0;
            state_q     <= StIssue;
          end
        end
        StIssue: begin
          start_q <= 1'b0;
          k_q     <= '0;
          tmr_q   <= TmrW'(1);
          state_q <= StRun;
        end
        StRun: begin
          tmr_q <= tmr_q + TmrW'(1);
          if (k_q == 5'(ITERATIONS - 1)) begin
            k_q     <= '0;
            state_q <= StWait;
          end else begin
            k_q <= k_q + 5'd1;
          end
        end
        StWait: begin
          tmr_q <= tmr_q + TmrW'(1);
          if (cordic_rdy) begin
            angle_q <= coords_zero ? '0 : angle_norm;
            zero_q  <= coords_zero;
            err_q   <= 1'b0;
            valid_q <= 1'b1;
            state_q <= StOut;
          end else if (tmr_q == TmrW'(ITERATIONS + 3)) begin
            // Iteration stage never answered: report an error with a zero angle.
            angle_q <= '0;
            zero_q  <= coords_zero;
            err_q   <= 1'b1;
            valid_q <= 1'b1;
            state_q <= StOut;
          end
        end
        StOut: begin
          if (bus.out_ready) begin
            valid_q <= 1'b0;
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  always_comb begin
    cordic_LUT_k = '0;
    case (cordic_k)
      5'd0:    cordic_LUT_k = ANGLE_DEPTH'(45);
      5'd1:    cordic_LUT_k = ANGLE_DEPTH'(27);
      5'd2:    cordic_LUT_k = ANGLE_DEPTH'(14);
      5'd3:    cordic_LUT_k = ANGLE_DEPTH'(7);
      5'd4:    cordic_LUT_k = ANGLE_DEPTH'(4);
      5'd5:    cordic_LUT_k = ANGLE_DEPTH'(2);
      5'd6:    cordic_LUT_k = ANGLE_DEPTH'(1);
      default: cordic_LUT_k = '0;
    endcase
  end

  assign bus.in_ready       = (state_q == StIdle);
  assign bus.out_valid      = valid_q;
  assign bus.angle_out      = angle_q;
  assign bus.out_zero       = zero_q;
  assign bus.out_err        = err_q;
  assign cordic_start       = start_q;
  assign cordic_k           = k_q;
  assign cordic_x           = x_q;
  assign cordic_y           = y_q;
  assign cordic_angle_begin = ang_begin_q;

endmodule

// File: tb/tb_cordic_sequencer.sv
// Bench for cordic_sequencer: directed and random vectors against a geometric reference,
// with a stub iteration stage that answers (or stays silent) on command.
module tb_cordic_sequencer;
  localparam int unsigned ITER = 20;
  localparam int unsigned CW   = 8;
  localparam int unsigned AW   = 10;
  localparam real         PI   = 3.14159265358979;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  cordic_sequencer_if #(.COORD_DEPTH(CW), .ANGLE_DEPTH(AW)) bus ();

  logic                 cordic_start;
  logic [4:0]           cordic_k;
  logic [AW-1:0]        cordic_LUT_k;
  logic signed [CW-1:0] cordic_x;
  logic signed [CW-1:0] cordic_y;
  logic [AW-1:0]        cordic_angle_begin;
  logic                 cordic_rdy;
  logic [AW-1:0]        cordic_angle;

  cordic_sequencer #(.ITERATIONS(ITER), .COORD_DEPTH(CW), .ANGLE_DEPTH(AW)) dut (
    .clk               (clk),
    .rst               (rst),
    .bus               (bus),
    .cordic_start      (cordic_start),
    .cordic_k          (cordic_k),
    .cordic_LUT_k      (cordic_LUT_k),
    .cordic_x          (cordic_x),
    .cordic_y          (cordic_y),
    .cordic_angle_begin(cordic_angle_begin),
    .cordic_rdy        (cordic_rdy),
    .cordic_angle      (cordic_angle)
  );

  int n_vec  = 0;
  int n_miss = 0;
  int lut_ref [8] = '{45, 27, 14, 7, 4, 2, 1, 0};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_miss++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_tol(input string tag, input int obs, input int exp, input int tol);
    int d;
    d = (((obs - exp) % 360) + 360) % 360;
    if (d > 180) d = 360 - d;
    n_vec++;
    assert (d <= tol) else begin
      n_miss++;
      $error("FAIL %s: observed %0d, expected %0d +/-%0d", tag, obs, exp, tol);
    end
  endtask

  // floor(v / 2)
  function automatic int half_floor(input int v);
    return (v < 0 && (v % 2) != 0) ? (v - 1) / 2 : v / 2;
  endfunction

  function automatic int geo_deg(input int xs, input int ys);
    real a;
    a = $atan2(real'(ys), real'(xs)) * 180.0 / PI;
    if (a < 0.0) a = a + 360.0;
    return int'(a);
  endfunction

  // Angle the stub iteration stage returns: start angle plus the residual rotation, mod 2^AW.
  function automatic int stub_raw(input int cx, input int cy, input int ab);
    int deg;
    deg = int'($atan2(real'(cy), real'(cx)) * 180.0 / PI);
    return (ab + deg + 1024) % 1024;
  endfunction

  function automatic int norm360(input int raw);
    return (raw >= 512) ? (raw + 360) % 1024 : raw;
  endfunction

  task automatic run_vector(input int x, input int y, input bit rdy_on, input int ret_override,
                            input int hold, input int spur_cycle);
    int xs, ys, cx, cy, ab, raw, exp_out, first_valid, starts;
    bit zero, k_ok, lut_ok, busy_ok, stable_ok, hold_ok;
    xs = half_floor(x);
    ys = half_floor(y);
    if (xs < 0) begin cx = -xs; cy = -ys; ab = 180; end
    else begin cx = xs; cy = ys; ab = 0; end
    zero    = (cx == 0) && (cy == 0);
    raw     = (ret_override >= 0) ? ret_override : stub_raw(cx, cy, ab);
    exp_out = (!rdy_on || zero) ? 0 : norm360(raw);

    @(negedge clk);
    check("in_ready_idle", 32'(bus.in_ready), 1);
    bus.in_valid = 1'b1;
    bus.x_in     = CW'(x);
    bus.y_in     = CW'(y);
    first_valid = -1; starts = 0;
    k_ok = 1'b1; lut_ok = 1'b1; busy_ok = 1'b1; stable_ok = 1'b1;
    for (int c = 1; c <= 60 && first_valid < 0; c++) begin
      @(negedge clk);
      bus.in_valid = 1'b0;
      bus.x_in     = CW'($urandom);
      bus.y_in     = CW'($urandom);
      cordic_rdy   = 1'b0;
      cordic_angle = AW'($urandom);
      if (cordic_start === 1'b1) starts++;
      if (bus.out_valid === 1'b1) first_valid = c;
      else if (bus.in_ready !== 1'b0) busy_ok = 1'b0;
      if (c == 1) begin
        check("cordic_x", 32'(cordic_x), cx);
        check("cordic_y", 32'(cordic_y), cy);
        check("angle_begin", 32'(cordic_angle_begin), ab);
        check("k_issue", 32'(cordic_k), 0);
      end else if (cordic_x !== CW'(cx) || cordic_y !== CW'(cy) ||
                   cordic_angle_begin !== AW'(ab)) begin
        stable_ok = 1'b0;
      end
      if (c >= 2 && c <= ITER + 1) begin
        if (cordic_k !== 5'(c - 2)) k_ok = 1'b0;
        if (cordic_LUT_k !== AW'((c - 2) < 8 ? lut_ref[(c - 2) % 8] : 0)) lut_ok = 1'b0;
      end
      if (c == spur_cycle) cordic_rdy = 1'b1;
      if (rdy_on && c == ITER + 2) begin
        cordic_rdy   = 1'b1;
        cordic_angle = AW'(raw);
      end
    end
    cordic_rdy = 1'b0;
    check("latency", 32'(first_valid), rdy_on ? ITER + 3 : ITER + 5);
    if (first_valid < 0) begin
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      return;
    end
    check("start_pulses", 32'(starts), 1);
    check("k_sequence", 32'(k_ok), 1);
    check("lut_sequence", 32'(lut_ok), 1);
    check("in_ready_busy", 32'(busy_ok), 1);
    check("angle_out", 32'(bus.angle_out), exp_out);
    check("out_err", 32'(bus.out_err), rdy_on ? 0 : 1);
    if (rdy_on) check("out_zero", 32'(bus.out_zero), zero ? 1 : 0);
    if (rdy_on && !zero) check_tol("angle_geo", int'(bus.angle_out), geo_deg(xs, ys), 3);

    hold_ok = 1'b1;
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      if (bus.out_valid !== 1'b1 || bus.angle_out !== AW'(exp_out) || bus.in_ready !== 1'b0 ||
          bus.out_err !== !rdy_on) hold_ok = 1'b0;
      if (cordic_x !== CW'(cx) || cordic_y !== CW'(cy) || cordic_angle_begin !== AW'(ab))
        stable_ok = 1'b0;
    end
    check("hold_stable", 32'(hold_ok), 1);
    check("coord_stable", 32'(stable_ok), 1);
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    check("in_ready_after", 32'(bus.in_ready), 1);
    check("out_valid_after", 32'(bus.out_valid), 0);
  endtask

  initial begin
    bit found;
    bus.in_valid  = 1'b0;
    bus.x_in      = '0;
    bus.y_in      = '0;
    bus.out_ready = 1'b0;
    cordic_rdy    = 1'b0;
    cordic_angle  = '0;

    #1 rst = 1'b1;
    #1;
    check("rst_in_ready", 32'(bus.in_ready), 1);
    check("rst_out_valid", 32'(bus.out_valid), 0);
    check("rst_start", 32'(cordic_start), 0);
    check("rst_k", 32'(cordic_k), 0);
    check("rst_angle_out", 32'(bus.angle_out), 0);
    check("rst_zero_err", 32'({bus.out_zero, bus.out_err}), 0);
    check("rst_coords", 32'({cordic_x, cordic_y, cordic_angle_begin}), 0);
    @(negedge clk);
    rst = 1'b0;

    run_vector(64, 0, 1'b1, -1, 0, 0);
    run_vector(-100, 0, 1'b1, -1, 1, 10);
    run_vector(10, -10, 1'b1, -1, 0, 5);
    run_vector(-128, -128, 1'b1, -1, 2, 0);
    run_vector(1, 1, 1'b1, 210, 0, 0);
    run_vector(50, 30, 1'b0, -1, 5, 0);

    // Reset in the middle of RUN must drop the vector on the spot.
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.x_in     = CW'(64);
    bus.y_in     = CW'(0);
    found = 1'b0;
    for (int c = 0; c < 40 && !found; c++) begin
      @(negedge clk);
      bus.in_valid = 1'b0;
      if (cordic_k === 5'd7) found = 1'b1;
    end
    check("k7_reached", 32'(found), 1);
    rst = 1'b1;
    #1;
    check("mid_rst_k", 32'(cordic_k), 0);
    check("mid_rst_start", 32'(cordic_start), 0);
    check("mid_rst_in_ready", 32'(bus.in_ready), 1);
    check("mid_rst_outs", 32'({bus.out_valid, bus.out_zero, bus.out_err, bus.angle_out}), 0);
    check("mid_rst_coords", 32'({cordic_x, cordic_y, cordic_angle_begin}), 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_in_ready", 32'(bus.in_ready), 1);
    run_vector(64, 0, 1'b1, -1, 0, 0);

    for (int i = 0; i < 10; i++) begin
      int x, y, hold, spur;
      x    = int'($urandom_range(255)) - 128;
      y    = int'($urandom_range(255)) - 128;
      hold = int'($urandom_range(3));
      spur = ($urandom_range(1) == 1) ? int'($urandom_range(ITER + 1, 3)) : 0;
      run_vector(x, y, 1'b1, -1, hold, spur);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
